usb_ep_ctrl: RTL and testbench
==============================

USB_EP_CTRL -- requirements
Module: usb_ep_ctrl

Interface
REQ-001 SHALL have parameter NUM_EP, default 4, number of endpoints served (EP0..NUM_EP-1, max 16).
REQ-002 SHALL have parameter MAX_PKT, default 64, max payload bytes per packet.
REQ-003 SHALL have port clk_48  in  1  48 MHz clock; the block uses one clock; reset is synchronous and active-low.
REQ-004 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have port usb_rst  in  1  bus reset from the USB core.
REQ-006 SHALL have ports transaction_active / direction_in / setup  in  1 each, plus endpoint  in  4, and success / data_strobe  in  1 each: the transaction side of the USB core.
REQ-007 SHALL have ports data_out  in  8  (received byte); data_in  out  8; data_in_valid  out  1.
REQ-008 SHALL have ports data_toggle  out  1  (expected/sent DATA0/1) and handshake  out  2  (00 ack, 01 none, 10 nak, 11 stall).
REQ-009 SHALL have ports ep_sel  out  4  (selected endpoint), ep_active  out  1, ep_dir_in  out  1, ep_setup  out  1.
REQ-010 SHALL have ports ep_in_avail  in  NUM_EP  (packet staged per EP), ep_in_data  in  8, ep_in_valid  in  1, ep_in_pop  out  1, ep_in_done  out  1, ep_in_rewind  out  1.
REQ-011 SHALL have ports ep_out_ready  in  NUM_EP  (space per EP), ep_out_data  out  8, ep_out_wr  out  1, ep_out_commit  out  1, ep_out_discard  out  1.
REQ-012 SHALL have ports ep_stall_set / ep_stall_clr  in  NUM_EP, and ep_stalled  out  NUM_EP.

Function
REQ-013 SHALL implement FSM S_IDLE, S_OUT, S_IN, S_END.
REQ-014 From S_IDLE, on transaction_active=1 with endpoint<NUM_EP: latch endpoint into ep_sel, clear byte count, go to S_IN if direction_in=1, else to S_OUT; ep_active=1 from the next cycle.
REQ-015 Endpoint>=NUM_EP: SHALL stay in S_IDLE and drive handshake=none.
REQ-016 Handshake, from registered state, valid while transaction_active: stalled EP and !setup -> stall; IN with !ep_in_avail[ep] -> nak; OUT with !ep_out_ready[ep] -> nak; setup -> ack always; otherwise ack.
REQ-017 Toggle state: tog_in[NUM_EP] and tog_out[NUM_EP]; data_toggle = tog_in[ep] if direction_in, else tog_out[ep].
REQ-018 On entry with setup=1, tog_out[ep] SHALL be forced to 0 in the same cycle; stall[ep] cleared.
REQ-019 On success in S_OUT: flip tog_out[ep]; if setup, set tog_in[ep]=1 and tog_out[ep]=1 instead.
REQ-020 On success in S_IN: flip tog_in[ep].
REQ-021 OUT path: while in S_OUT, data_strobe with count<MAX_PKT -> ep_out_wr=1, ep_out_data=data_out, count+1; a strobe at count=MAX_PKT sets an overflow flag and no write.
REQ-022 IN path: data_in=ep_in_data; data_in_valid = S_IN && ep_in_valid && count<MAX_PKT; data_strobe -> ep_in_pop=1, count+1.
REQ-023 Count is 7 bits and SHALL saturate; no wrap.
REQ-024 Transaction end (transaction_active 1->0), one-cycle pulse in S_END:
- OUT with success and no overflow -> ep_out_commit.
- OUT otherwise -> ep_out_discard.
- IN with success -> ep_in_done.
- IN otherwise -> ep_in_rewind.
Then go to S_IDLE.
REQ-025 success and the transaction_active fall in the same cycle SHALL count as success.
REQ-026 ep_stall_set and ep_stall_clr asserted together: set wins; ep_stalled = stall register.
REQ-027 usb_rst=1: clear all toggles and stalls, go to S_IDLE, no commit/done pulses; pending OUT -> ep_out_discard, pending IN -> ep_in_rewind, same cycle; highest priority after rst_n.

Reset
REQ-028 On rst_n=0 at clk_48 edge: state S_IDLE; all toggles, stalls and count 0; ep_sel 0; all pulse outputs, ep_active, data_in_valid 0; handshake=none.
REQ-029 rst_n mid-transaction SHALL abort silently, with no commit/discard/done/rewind pulse.

Structure
REQ-030 Handshake codes (hs_ack/none/nak/stall) and FSM state encodings SHALL live in shared package usb_pkg, reused by the core.
REQ-031 Per-endpoint toggle/stall storage SHALL be sub-module usb_ep_state (NUM_EP entries, flip/set/clear ports).

Verification
REQ-032 OUT EP1, ready, 3 bytes 0xA5,0x5A,0xFF, success -> 3 ep_out_wr with those bytes, 1 commit, tog_out[1] 0->1.
REQ-033 IN EP2, avail, 4 bytes, success -> 4 pops, ep_in_done, tog_in[2] flipped; repeat without success -> ep_in_rewind, toggle unchanged.
REQ-034 SETUP EP0 while stalled -> handshake ack, stall cleared, data_toggle 0; after success tog_in[0]=tog_out[0]=1.
REQ-035 OUT EP3, 65 strobes -> 64 writes, ep_out_discard, toggle flipped only on success; ep_out_ready[3]=0 -> handshake nak.
REQ-036 usb_rst mid-IN -> ep_in_rewind, all toggles and stalls 0, S_IDLE; endpoint=5 with NUM_EP=4 -> handshake none, no ep_active.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared encodings for the USB endpoint controller: handshake codes and FSM states.
package usb_pkg;

   typedef enum logic [1:0] {
      hs_ack   = 2'b00,
      hs_none  = 2'b01,
      hs_nak   = 2'b10,
      hs_stall = 2'b11
   } hs_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OUT  = 2'd1,
      S_IN   = 2'd2,
      S_END  = 2'd3
   } fsm_t;

endpackage

// File: rtl/usb_ep_ctrl_if.sv
// Transaction-side bus between the USB protocol core (master) and the endpoint controller (slave).
interface usb_ep_ctrl_if;
   import usb_pkg::*;

   logic       transaction_active;
   logic       direction_in;
   logic       setup;
   logic [3:0] endpoint;
   logic       success;
   logic       data_strobe;
   logic [7:0] data_out;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_toggle;
   hs_t        handshake;

   modport master (
      output transaction_active, direction_in, setup, endpoint, success, data_strobe, data_out,
      input  data_in, data_in_valid, data_toggle, handshake
   );

   modport slave (
      input  transaction_active, direction_in, setup, endpoint, success, data_strobe, data_out,
      output data_in, data_in_valid, data_toggle, handshake
   );

endinterface

// File: rtl/usb_ep_state.sv
// Per-endpoint DATA0/1 toggles and stall flags. Priority per bit: set > clear > flip.
module usb_ep_state #(
   parameter int NUM_EP = 4
) (
   input  logic              clk_48,
   input  logic              rst_n,
   input  logic              clr_all,
   input  logic [NUM_EP-1:0] tog_in_flip,
   input  logic [NUM_EP-1:0] tog_in_set,
   input  logic [NUM_EP-1:0] tog_out_flip,
   input  logic [NUM_EP-1:0] tog_out_set,
   input  logic [NUM_EP-1:0] tog_out_clr,
   input  logic [NUM_EP-1:0] stall_set,
   input  logic [NUM_EP-1:0] stall_clr,
   output logic [NUM_EP-1:0] tog_in,
   output logic [NUM_EP-1:0] tog_out,
   output logic [NUM_EP-1:0] stalled
);

   // toggle and stall storage; bus reset wipes everything like rst_n
   always_ff @(posedge clk_48) begin
      if (!rst_n || clr_all) begin
         tog_in  <= '0;
         tog_out <= '0;
         stalled <= '0;
      end else begin
         tog_in  <= tog_in_set | (tog_in ^ tog_in_flip);
         tog_out <= tog_out_set | ((tog_out ^ tog_out_flip) & ~tog_out_clr);
         stalled <= stall_set | (stalled & ~stall_clr);
      end
   end

endmodule

// File: rtl/usb_ep_ctrl.sv
// USB endpoint controller: routes one transaction at a time to the selected endpoint's
// IN/OUT buffer, tracks data toggles and stalls, and produces the handshake code.
//
// state  | meaning
// S_IDLE | no transaction; waiting for transaction_active on a valid endpoint
// S_OUT  | host->device data phase; strobes write into the OUT buffer
// S_IN   | device->host data phase; strobes pop the IN buffer
// S_END  | one-cycle commit/discard/done/rewind pulse, then back to idle
module usb_ep_ctrl #(
   parameter int NUM_EP  = 4,
   parameter int MAX_PKT = 64
) (
   input  logic              clk_48,
   input  logic              rst_n,
   input  logic              usb_rst,
   usb_ep_ctrl_if.slave      bus,
   output logic [3:0]        ep_sel,
   output logic              ep_active,
   output logic              ep_dir_in,
   output logic              ep_setup,
   input  logic [NUM_EP-1:0] ep_in_avail,
   input  logic [7:0]        ep_in_data,
   input  logic              ep_in_valid,
   output logic              ep_in_pop,
   output logic              ep_in_done,
   output logic              ep_in_rewind,
   input  logic [NUM_EP-1:0] ep_out_ready,
   output logic [7:0]        ep_out_data,
   output logic              ep_out_wr,
   output logic              ep_out_commit,
   output logic              ep_out_discard,
   input  logic [NUM_EP-1:0] ep_stall_set,
   input  logic [NUM_EP-1:0] ep_stall_clr,
   output logic [NUM_EP-1:0] ep_stalled
);
   import usb_pkg::*;

   localparam logic [6:0] MAX_CNT  = 7'(MAX_PKT);
   localparam logic [4:0] NUM_EP_W = 5'(NUM_EP);

   fsm_t              state, state_nxt;
   logic [6:0]        cnt;
   logic              ovf, dir_q, setup_q, succ_q;
   logic [NUM_EP-1:0] ep_mask, ent_mask;
   logic [NUM_EP-1:0] tog_in, tog_out;
   logic [NUM_EP-1:0] tog_in_flip, tog_in_set, tog_out_flip, tog_out_set, tog_out_clr, stall_clr;
   logic              clr_all, ep_ok, cnt_lt_max, in_xfer;
   hs_t               hs;

   // one-hot masks avoid indexing NUM_EP-wide vectors with a 4-bit endpoint number
   assign ep_mask    = NUM_EP'(1) << ep_sel;
   assign ent_mask   = NUM_EP'(1) << bus.endpoint;
   assign ep_ok      = {1'b0, bus.endpoint} < NUM_EP_W;
   assign cnt_lt_max = cnt < MAX_CNT;
   assign in_xfer    = (state == S_IN);

   assign ep_active        = (state == S_OUT) || (state == S_IN);
   assign ep_dir_in        = dir_q;
   assign ep_setup         = setup_q;
   assign ep_out_data      = bus.data_out;
   assign bus.data_in      = ep_in_data;
   assign bus.data_in_valid = in_xfer && ep_in_valid && cnt_lt_max;
   assign bus.data_toggle  = dir_q ? |(tog_in & ep_mask) : |(tog_out & ep_mask);
   assign bus.handshake    = hs;

   // handshake decoded from the latched transaction, only while the core holds the transaction open
   always_comb begin
      hs = hs_none;
      if (ep_active && bus.transaction_active) begin
         if (setup_q)                            hs = hs_ack;
         else if (|(ep_stalled & ep_mask))       hs = hs_stall;
         else if (dir_q && !(|(ep_in_avail & ep_mask)))   hs = hs_nak;
         else if (!dir_q && !(|(ep_out_ready & ep_mask))) hs = hs_nak;
         else                                    hs = hs_ack;
      end
   end

   // next state, buffer strobes, end-of-transaction pulses and toggle/stall updates
   always_comb begin
      state_nxt      = state;
      ep_out_wr      = 1'b0;
      ep_in_pop      = 1'b0;
      ep_out_commit  = 1'b0;
      ep_out_discard = 1'b0;
      ep_in_done     = 1'b0;
      ep_in_rewind   = 1'b0;
      clr_all        = 1'b0;
      tog_in_flip    = '0;
      tog_in_set     = '0;
      tog_out_flip   = '0;
      tog_out_set    = '0;
      tog_out_clr    = '0;
      stall_clr      = ep_stall_clr;
      if (!rst_n) begin
         state_nxt = S_IDLE;
      end else if (usb_rst) begin
         state_nxt = S_IDLE;
         clr_all   = 1'b1;
         if (state != S_IDLE) begin
            ep_out_discard = !dir_q;
            ep_in_rewind   = dir_q;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.transaction_active && ep_ok) begin
                  state_nxt = bus.direction_in ? S_IN : S_OUT;
                  if (bus.setup) begin
                     tog_out_clr = ent_mask;
                     stall_clr   = ep_stall_clr | ent_mask;
                  end
               end
            end
            S_OUT: begin
               ep_out_wr = bus.data_strobe && cnt_lt_max;
               if (bus.success && !succ_q) begin
                  if (setup_q) begin
                     tog_in_set  = ep_mask;
                     tog_out_set = ep_mask;
                  end else begin
                     tog_out_flip = ep_mask;
                  end
               end
               if (!bus.transaction_active) state_nxt = S_END;
            end
            S_IN: begin
               ep_in_pop = bus.data_strobe;
               if (bus.success && !succ_q) tog_in_flip = ep_mask;
               if (!bus.transaction_active) state_nxt = S_END;
            end
            S_END: begin
               ep_out_commit  = !dir_q && succ_q && !ovf;
               ep_out_discard = !dir_q && !(succ_q && !ovf);
               ep_in_done     = dir_q && succ_q;
               ep_in_rewind   = dir_q && !succ_q;
               state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // state register
   always_ff @(posedge clk_48) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // transaction context: endpoint, direction, byte count, overflow and success latches
   always_ff @(posedge clk_48) begin
      if (!rst_n) begin
         ep_sel  <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         dir_q   <= 1'b0;
         setup_q <= 1'b0;
         succ_q  <= 1'b0;
      end else if (state == S_IDLE && state_nxt != S_IDLE) begin
         ep_sel  <= bus.endpoint;
         cnt     <= '0;
         ovf     <= 1'b0;
         dir_q   <= bus.direction_in;
         setup_q <= bus.setup;
         succ_q  <= 1'b0;
      end else if (!usb_rst && ep_active) begin
         if ((ep_out_wr || ep_in_pop) && cnt != 7'h7f) cnt <= cnt + 7'd1;
         if (state == S_OUT && bus.data_strobe && !cnt_lt_max) ovf <= 1'b1;
         if (bus.success) succ_q <= 1'b1;
      end
   end

   usb_ep_state #(.NUM_EP(NUM_EP)) u_state (
      .clk_48       (clk_48),
      .rst_n        (rst_n),
      .clr_all      (clr_all),
      .tog_in_flip  (tog_in_flip),
      .tog_in_set   (tog_in_set),
      .tog_out_flip (tog_out_flip),
      .tog_out_set  (tog_out_set),
      .tog_out_clr  (tog_out_clr),
      .stall_set    (ep_stall_set),
      .stall_clr    (stall_clr),
      .tog_in       (tog_in),
      .tog_out      (tog_out),
      .stalled      (ep_stalled)
   );

endmodule

// File: tb/tb_usb_ep_ctrl.sv
// Directed bench for usb_ep_ctrl with hand-computed expectations.
module tb_usb_ep_ctrl;

   localparam logic [1:0] HS_ACK   = 2'b00;
   localparam logic [1:0] HS_NONE  = 2'b01;
   localparam logic [1:0] HS_NAK   = 2'b10;
   localparam logic [1:0] HS_STALL = 2'b11;

   logic       clk_48 = 1'b0;
   logic       rst_n  = 1'b0;
   logic       usb_rst = 1'b0;
   logic [3:0] ep_sel;
   logic       ep_active, ep_dir_in, ep_setup;
   logic [3:0] ep_in_avail;
   logic [7:0] ep_in_data;
   logic       ep_in_valid, ep_in_pop, ep_in_done, ep_in_rewind;
   logic [3:0] ep_out_ready;
   logic [7:0] ep_out_data;
   logic       ep_out_wr, ep_out_commit, ep_out_discard;
   logic [3:0] ep_stall_set, ep_stall_clr, ep_stalled;

   usb_ep_ctrl_if bus();

   usb_ep_ctrl #(.NUM_EP(4), .MAX_PKT(64)) dut (
      .clk_48         (clk_48),
      .rst_n          (rst_n),
      .usb_rst        (usb_rst),
      .bus            (bus),
      .ep_sel         (ep_sel),
      .ep_active      (ep_active),
      .ep_dir_in      (ep_dir_in),
      .ep_setup       (ep_setup),
      .ep_in_avail    (ep_in_avail),
      .ep_in_data     (ep_in_data),
      .ep_in_valid    (ep_in_valid),
      .ep_in_pop      (ep_in_pop),
      .ep_in_done     (ep_in_done),
      .ep_in_rewind   (ep_in_rewind),
      .ep_out_ready   (ep_out_ready),
      .ep_out_data    (ep_out_data),
      .ep_out_wr      (ep_out_wr),
      .ep_out_commit  (ep_out_commit),
      .ep_out_discard (ep_out_discard),
      .ep_stall_set   (ep_stall_set),
      .ep_stall_clr   (ep_stall_clr),
      .ep_stalled     (ep_stalled)
   );

   always #10 clk_48 = ~clk_48;

   int n_chk = 0;
   int n_bad = 0;

   int wr_cnt = 0, pop_cnt = 0, cm_cnt = 0, dc_cnt = 0, dn_cnt = 0, rw_cnt = 0;
   int wr0, pop0, cm0, dc0, dn0, rw0;
   logic [7:0] wr_log [0:255];

   // pulse counters and OUT byte log, sampled mid-cycle
   always @(negedge clk_48) begin
      if (ep_out_wr) begin
         if (wr_cnt < 256) wr_log[wr_cnt] = ep_out_data;
         wr_cnt++;
      end
      if (ep_in_pop)      pop_cnt++;
      if (ep_out_commit)  cm_cnt++;
      if (ep_out_discard) dc_cnt++;
      if (ep_in_done)     dn_cnt++;
      if (ep_in_rewind)   rw_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_48);
         #1;
      end
   endtask

   task automatic snap();
      wr0 = wr_cnt; pop0 = pop_cnt; cm0 = cm_cnt; dc0 = dc_cnt; dn0 = dn_cnt; rw0 = rw_cnt;
   endtask

   task automatic start_xfer(input logic [3:0] ep, input logic dir, input logic stp);
      bus.transaction_active = 1'b1;
      bus.endpoint           = ep;
      bus.direction_in       = dir;
      bus.setup              = stp;
      step(1);
   endtask

   task automatic strobe_byte(input logic [7:0] b);
      bus.data_strobe = 1'b1;
      bus.data_out    = b;
      step(1);
      bus.data_strobe = 1'b0;
   endtask

   task automatic end_xfer(input logic ok);
      bus.transaction_active = 1'b0;
      bus.success            = ok;
      step(1);
      bus.success = 1'b0;
      bus.setup   = 1'b0;
      step(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      bus.transaction_active = 1'b1;
      bus.direction_in = 1'b0;
      bus.setup        = 1'b0;
      bus.endpoint     = 4'd2;
      bus.success      = 1'b0;
      bus.data_strobe  = 1'b0;
      bus.data_out     = 8'h00;
      ep_in_avail  = 4'hF;
      ep_out_ready = 4'hF;
      ep_in_data   = 8'h3C;
      ep_in_valid  = 1'b1;
      ep_stall_set = 4'h0;
      ep_stall_clr = 4'h0;

      // reset held with a transaction request pending
      step(2);
      check_eq("rst_hs", 32'(bus.handshake), 32'(HS_NONE));
      check_eq("rst_active", 32'(ep_active), 32'd0);
      check_eq("rst_ep_sel", 32'(ep_sel), 32'd0);
      check_eq("rst_stalled", 32'(ep_stalled), 32'd0);
      check_eq("rst_din_valid", 32'(bus.data_in_valid), 32'd0);
      check_eq("rst_pulses", 32'(cm_cnt + dc_cnt + dn_cnt + rw_cnt + wr_cnt + pop_cnt), 32'd0);
      bus.transaction_active = 1'b0;
      rst_n = 1'b1;
      step(1);

      // OUT EP1, three bytes, success
      snap();
      start_xfer(4'd1, 1'b0, 1'b0);
      check_eq("out1_active", 32'(ep_active), 32'd1);
      check_eq("out1_sel", 32'(ep_sel), 32'd1);
      check_eq("out1_hs", 32'(bus.handshake), 32'(HS_ACK));
      check_eq("out1_tog_pre", 32'(bus.data_toggle), 32'd0);
      strobe_byte(8'hA5);
      strobe_byte(8'h5A);
      strobe_byte(8'hFF);
      end_xfer(1'b1);
      check_eq("out1_wr", 32'(wr_cnt - wr0), 32'd3);
      check_eq("out1_b0", 32'(wr_log[wr0]), 32'hA5);
      check_eq("out1_b1", 32'(wr_log[wr0+1]), 32'h5A);
      check_eq("out1_b2", 32'(wr_log[wr0+2]), 32'hFF);
      check_eq("out1_commit", 32'(cm_cnt - cm0), 32'd1);
      check_eq("out1_discard", 32'(dc_cnt - dc0), 32'd0);
      check_eq("out1_tog_post", 32'(bus.data_toggle), 32'd1);
      check_eq("out1_idle", 32'(ep_active), 32'd0);

      // IN EP2, four bytes, success then a retry without success
      snap();
      start_xfer(4'd2, 1'b1, 1'b0);
      check_eq("in2_hs", 32'(bus.handshake), 32'(HS_ACK));
      check_eq("in2_valid", 32'(bus.data_in_valid), 32'd1);
      check_eq("in2_data", 32'(bus.data_in), 32'h3C);
      check_eq("in2_tog_pre", 32'(bus.data_toggle), 32'd0);
      repeat (4) strobe_byte(8'h00);
      end_xfer(1'b1);
      check_eq("in2_pop", 32'(pop_cnt - pop0), 32'd4);
      check_eq("in2_done", 32'(dn_cnt - dn0), 32'd1);
      check_eq("in2_rewind", 32'(rw_cnt - rw0), 32'd0);
      check_eq("in2_tog_post", 32'(bus.data_toggle), 32'd1);
      snap();
      start_xfer(4'd2, 1'b1, 1'b0);
      repeat (4) strobe_byte(8'h00);
      end_xfer(1'b0);
      check_eq("in2r_pop", 32'(pop_cnt - pop0), 32'd4);
      check_eq("in2r_rewind", 32'(rw_cnt - rw0), 32'd1);
      check_eq("in2r_done", 32'(dn_cnt - dn0), 32'd0);
      check_eq("in2r_tog", 32'(bus.data_toggle), 32'd1);

      // stall set/clear; set wins when both asserted
      ep_stall_set = 4'b0011; ep_stall_clr = 4'b0010;
      step(1);
      ep_stall_set = 4'b0000; ep_stall_clr = 4'b0000;
      check_eq("stall_setwins", 32'(ep_stalled), 32'b0011);
      ep_stall_clr = 4'b0010;
      step(1);
      ep_stall_clr = 4'b0000;
      check_eq("stall_clr", 32'(ep_stalled), 32'b0001);

      // SETUP on stalled EP0
      snap();
      start_xfer(4'd0, 1'b0, 1'b1);
      check_eq("setup_hs", 32'(bus.handshake), 32'(HS_ACK));
      check_eq("setup_unstall", 32'(ep_stalled), 32'd0);
      check_eq("setup_tog", 32'(bus.data_toggle), 32'd0);
      check_eq("setup_flag", 32'(ep_setup), 32'd1);
      strobe_byte(8'h80);
      strobe_byte(8'h06);
      end_xfer(1'b1);
      check_eq("setup_commit", 32'(cm_cnt - cm0), 32'd1);
      check_eq("setup_tog_out", 32'(bus.data_toggle), 32'd1);
      snap();
      start_xfer(4'd0, 1'b1, 1'b0);
      check_eq("setup_tog_in", 32'(bus.data_toggle), 32'd1);
      end_xfer(1'b0);
      check_eq("ep0_in_rewind", 32'(rw_cnt - rw0), 32'd1);

      // stalled IN, then not-available IN
      ep_stall_set = 4'b0100;
      step(1);
      ep_stall_set = 4'b0000;
      start_xfer(4'd2, 1'b1, 1'b0);
      check_eq("in2_stall_hs", 32'(bus.handshake), 32'(HS_STALL));
      end_xfer(1'b0);
      ep_stall_clr = 4'b0100;
      step(1);
      ep_stall_clr = 4'b0000;
      ep_in_avail = 4'b1011;
      start_xfer(4'd2, 1'b1, 1'b0);
      check_eq("in2_nak_hs", 32'(bus.handshake), 32'(HS_NAK));
      end_xfer(1'b0);
      ep_in_avail = 4'hF;

      // OUT EP3 overflow: 65 strobes, success still flips the toggle
      snap();
      start_xfer(4'd3, 1'b0, 1'b0);
      for (int i = 0; i < 65; i++) strobe_byte(8'(i));
      end_xfer(1'b1);
      check_eq("ovf_wr", 32'(wr_cnt - wr0), 32'd64);
      check_eq("ovf_last", 32'(wr_log[wr0+63]), 32'h3F);
      check_eq("ovf_discard", 32'(dc_cnt - dc0), 32'd1);
      check_eq("ovf_commit", 32'(cm_cnt - cm0), 32'd0);
      check_eq("ovf_tog", 32'(bus.data_toggle), 32'd1);
      ep_out_ready = 4'b0111;
      snap();
      start_xfer(4'd3, 1'b0, 1'b0);
      check_eq("out3_nak_hs", 32'(bus.handshake), 32'(HS_NAK));
      end_xfer(1'b0);
      check_eq("out3_nak_discard", 32'(dc_cnt - dc0), 32'd1);
      check_eq("out3_nak_tog", 32'(bus.data_toggle), 32'd1);
      ep_out_ready = 4'hF;

      // bus reset in the middle of an IN on EP2
      ep_stall_set = 4'b0010;
      step(1);
      ep_stall_set = 4'b0000;
      snap();
      start_xfer(4'd2, 1'b1, 1'b0);
      check_eq("usbrst_tog_pre", 32'(bus.data_toggle), 32'd1);
      strobe_byte(8'h00);
      usb_rst = 1'b1;
      bus.transaction_active = 1'b0;
      step(1);
      usb_rst = 1'b0;
      check_eq("usbrst_rewind", 32'(rw_cnt - rw0), 32'd1);
      check_eq("usbrst_done", 32'(dn_cnt - dn0), 32'd0);
      check_eq("usbrst_discard", 32'(dc_cnt - dc0), 32'd0);
      check_eq("usbrst_stalled", 32'(ep_stalled), 32'd0);
      check_eq("usbrst_idle", 32'(ep_active), 32'd0);
      check_eq("usbrst_hs", 32'(bus.handshake), 32'(HS_NONE));
      check_eq("usbrst_tog_in2", 32'(bus.data_toggle), 32'd0);
      step(1);
      start_xfer(4'd1, 1'b0, 1'b0);
      check_eq("usbrst_tog_out1", 32'(bus.data_toggle), 32'd0);
      end_xfer(1'b0);

      // endpoint beyond NUM_EP is ignored
      snap();
      bus.transaction_active = 1'b1;
      bus.endpoint = 4'd5;
      bus.direction_in = 1'b0;
      step(1);
      check_eq("ep5_hs", 32'(bus.handshake), 32'(HS_NONE));
      check_eq("ep5_active", 32'(ep_active), 32'd0);
      step(1);
      check_eq("ep5_active2", 32'(ep_active), 32'd0);
      bus.transaction_active = 1'b0;
      step(2);
      check_eq("ep5_pulses", 32'(cm_cnt - cm0 + dc_cnt - dc0 + wr_cnt - wr0), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
